// File: rtl/e_mdu_param_if.sv
// Handshake/bus bundle between the E stage and the multiply/divide unit.
interface e_mdu_param_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       MDUOp;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic             Start;
  logic             Flush;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Done;
  logic             DivZero;

  modport master (
    output MDUOp, D1, D2, Start, Flush,
    input  Busy, HI, LO, Done, DivZero
  );

  modport slave (
    input  MDUOp, D1, D2, Start, Flush,
    output Busy, HI, LO, Done, DivZero
  );
endinterface

// File: rtl/e_mdu_param.sv
// Parametrised multiply/divide unit: owns HI/LO, runs mult/div/madd/msub as
// fixed-latency operations and reports Busy, Done and DivZero.
module e_mdu_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic          clk,
  input  logic          reset,
  e_mdu_param_if.slave  mdu
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } op_e;

  logic [CW-1:0]    cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  op_e                op_in;
  logic               busy;
  logic               is_mul_in;
  logic               is_div_in;
  logic               signed_op;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, hilo;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_abs, b_abs, b_safe, q_u, r_u, quo, rem;

  assign op_in = op_e'(mdu.MDUOp);
  assign busy  = (cnt_q != '0);

  assign is_mul_in = op_in inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  assign is_div_in = op_in inside {OP_DIV, OP_DIVU};

  // Result datapath, evaluated from the latched operands and op.
  // Signed division runs on magnitudes and re-applies the signs afterwards;
  // MIN / -1 falls out naturally as quotient MIN, remainder 0.
  always_comb begin
    signed_op = op_q inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    ext_a     = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b     = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = ext_a * ext_b;
    hilo      = {hi_q, lo_q};
    a_neg     = signed_op & a_q[WIDTH-1];
    b_neg     = signed_op & b_q[WIDTH-1];
    a_abs     = a_neg ? ('0 - a_q) : a_q;
    b_abs     = b_neg ? ('0 - b_q) : b_q;
    b_zero    = (b_q == '0);
    b_safe    = b_zero ? WIDTH'(1) : b_abs;
    q_u       = a_abs / b_safe;
    r_u       = a_abs % b_safe;
    quo       = (a_neg ^ b_neg) ? ('0 - q_u) : q_u;
    rem       = a_neg ? ('0 - r_u) : r_u;
  end

  // Next-state: flush beats commit; launch and moves only when idle.
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    dz_d   = 1'b0;
    if (mdu.Flush) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(1)) begin
      cnt_d  = '0;
      done_d = 1'b1;
      case (op_q)
        OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
        OP_MADD, OP_MADDU: {hi_d, lo_d} = hilo + prod;
        OP_MSUB, OP_MSUBU: {hi_d, lo_d} = hilo - prod;
        OP_DIV, OP_DIVU: begin
          if (b_zero) begin
            dz_d = 1'b1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
        default: ;
      endcase
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      if (mdu.Start && (is_mul_in || is_div_in)) begin
        op_d  = op_in;
        a_d   = mdu.D1;
        b_d   = mdu.D2;
        cnt_d = is_div_in ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      end
      if (op_in == OP_MTHI) hi_d = mdu.D1;
      if (op_in == OP_MTLO) lo_d = mdu.D1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      op_q   <= OP_NONE;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  assign mdu.Busy    = busy;
  assign mdu.HI      = hi_q;
  assign mdu.LO      = lo_q;
  assign mdu.Done    = done_q;
  assign mdu.DivZero = dz_q;

endmodule

// File: tb/tb_e_mdu_param.sv
// Self-checking bench for e_mdu_param (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
module tb_e_mdu_param;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  e_mdu_param_if #(.WIDTH(32)) mdu ();

  e_mdu_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        pre;
    logic [31:0] phi;
    logic [31:0] plo;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                              input logic pre, input logic [31:0] phi, input logic [31:0] plo,
                              input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    vec_t v;
    v.op = op; v.d1 = d1; v.d2 = d2; v.pre = pre; v.phi = phi; v.plo = plo;
    v.ehi = ehi; v.elo = elo; v.edz = edz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hilo(input logic [31:0] hi, input logic [31:0] lo);
    mdu.MDUOp = 4'd7; mdu.D1 = hi; tick();
    mdu.MDUOp = 4'd8; mdu.D1 = lo; tick();
    mdu.MDUOp = 4'd0;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2);
    mdu.MDUOp = op; mdu.D1 = d1; mdu.D2 = d2; mdu.Start = 1'b1;
    tick();
    mdu.Start = 1'b0; mdu.MDUOp = 4'd0;
  endtask

  // Counts cycles with Busy high; stops on the first idle cycle or after 40.
  task automatic wait_idle(output int n);
    n = 0;
    while (mdu.Busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int exp_n;
    logic seen_done;

    mdu.MDUOp = '0; mdu.D1 = '0; mdu.D2 = '0; mdu.Start = 1'b0; mdu.Flush = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_busy", 64'(mdu.Busy), 64'd0);
    chk("rst_hi",   64'(mdu.HI),   64'd0);
    chk("rst_lo",   64'(mdu.LO),   64'd0);
    chk("rst_done", 64'(mdu.Done), 64'd0);
    chk("rst_dz",   64'(mdu.DivZero), 64'd0);

    vecs[0]  = mk(4'd1,  32'hFFFFFFFD, 32'd5,        1, 32'h5, 32'h6,        32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    vecs[1]  = mk(4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h0, 32'h0,        32'hFFFFFFFE, 32'h00000001, 0);
    vecs[2]  = mk(4'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0, 32'h0,        32'h0,        32'h1,        0);
    vecs[3]  = mk(4'd3,  32'd7,        32'hFFFFFFFE, 0, 32'h0, 32'h0,        32'h1,        32'hFFFFFFFD, 0);
    vecs[4]  = mk(4'd3,  32'hFFFFFFF9, 32'd2,        0, 32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    vecs[5]  = mk(4'd3,  32'h80000000, 32'hFFFFFFFF, 0, 32'h0, 32'h0,        32'h0,        32'h80000000, 0);
    vecs[6]  = mk(4'd4,  32'hFFFFFFFF, 32'h10,       0, 32'h0, 32'h0,        32'hF,        32'h0FFFFFFF, 0);
    vecs[7]  = mk(4'd4,  32'd9,        32'd0,        1, 32'h11, 32'h22,      32'h11,       32'h22,       1);
    vecs[8]  = mk(4'd3,  32'hFFFFFFF9, 32'd0,        1, 32'h1, 32'h2,        32'h1,        32'h2,        1);
    vecs[9]  = mk(4'd9,  32'd1,        32'd1,        1, 32'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        0);
    vecs[10] = mk(4'd9,  32'hFFFFFFFF, 32'd1,        1, 32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    vecs[11] = mk(4'd10, 32'hFFFFFFFF, 32'd2,        1, 32'h0, 32'h0,        32'h1,        32'hFFFFFFFE, 0);
    vecs[12] = mk(4'd10, 32'd2,        32'd2,        1, 32'h0, 32'h0,        32'h0,        32'h4,        0);
    vecs[13] = mk(4'd12, 32'd2,        32'd3,        0, 32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    vecs[14] = mk(4'd11, 32'hFFFFFFFE, 32'd3,        1, 32'h0, 32'h0,        32'h0,        32'h6,        0);
    vecs[15] = mk(4'd4,  32'd7,        32'd2,        0, 32'h0, 32'h0,        32'h1,        32'h3,        0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pre) begin
        set_hilo(vecs[i].phi, vecs[i].plo);
        chk($sformatf("v%0d_pre", i), {mdu.HI, mdu.LO}, {vecs[i].phi, vecs[i].plo});
      end
      exp_n = (vecs[i].op == 4'd3 || vecs[i].op == 4'd4) ? 10 : 5;
      launch(vecs[i].op, vecs[i].d1, vecs[i].d2);
      wait_idle(n);
      chk($sformatf("v%0d_busy_len", i), 64'(n), 64'(exp_n));
      chk($sformatf("v%0d_done", i), 64'(mdu.Done), 64'd1);
      chk($sformatf("v%0d_dz", i), 64'(mdu.DivZero), 64'(vecs[i].edz));
      chk($sformatf("v%0d_hi", i), 64'(mdu.HI), 64'(vecs[i].ehi));
      chk($sformatf("v%0d_lo", i), 64'(mdu.LO), 64'(vecs[i].elo));
      tick();
      chk($sformatf("v%0d_done_once", i), {63'd0, mdu.Done | mdu.DivZero}, 64'd0);
    end

    // Flush on the third busy cycle of a mult.
    set_hilo(32'h12, 32'h34);
    launch(4'd1, 32'd3, 32'd4);
    tick(); tick();
    mdu.Flush = 1'b1; tick(); mdu.Flush = 1'b0;
    chk("flush_busy", 64'(mdu.Busy), 64'd0);
    chk("flush_hilo", {mdu.HI, mdu.LO}, {32'h12, 32'h34});
    seen_done = mdu.Done;
    for (int k = 0; k < 6; k++) begin tick(); seen_done |= mdu.Done; end
    chk("flush_no_done", 64'(seen_done), 64'd0);

    // Flush coinciding with the commit edge.
    launch(4'd1, 32'd3, 32'd4);
    tick(); tick(); tick(); tick();
    mdu.Flush = 1'b1; tick(); mdu.Flush = 1'b0;
    chk("flush_commit_busy", 64'(mdu.Busy), 64'd0);
    chk("flush_commit_done", 64'(mdu.Done), 64'd0);
    chk("flush_commit_hilo", {mdu.HI, mdu.LO}, {32'h12, 32'h34});

    // Start and mtlo while busy are ignored.
    launch(4'd1, 32'd3, 32'd4);
    tick();
    mdu.MDUOp = 4'd3; mdu.D1 = 32'd100; mdu.D2 = 32'd7; mdu.Start = 1'b1; tick();
    mdu.Start = 1'b0; mdu.MDUOp = 4'd8; mdu.D1 = 32'hAB; tick();
    mdu.MDUOp = 4'd0;
    chk("busy_mtlo_lo", 64'(mdu.LO), 64'h34);
    wait_idle(n);
    chk("busy_start_len", 64'(n), 64'd2);
    chk("busy_start_res", {mdu.HI, mdu.LO}, {32'h0, 32'hC});

    // Back-to-back launch in the Done cycle.
    launch(4'd1, 32'd4, 32'd5);
    chk("b2b_busy", 64'(mdu.Busy), 64'd1);
    chk("b2b_keep", {mdu.HI, mdu.LO}, {32'h0, 32'hC});
    wait_idle(n);
    chk("b2b_len", 64'(n), 64'd5);
    chk("b2b_res", {mdu.HI, mdu.LO}, {32'h0, 32'd20});

    // Flush suppresses a same-cycle launch and move.
    set_hilo(32'h1, 32'h2);
    mdu.Flush = 1'b1; mdu.Start = 1'b1; mdu.MDUOp = 4'd1; mdu.D1 = 32'd2; mdu.D2 = 32'd2; tick();
    mdu.Start = 1'b0; mdu.MDUOp = 4'd7; mdu.D1 = 32'h99; tick();
    mdu.Flush = 1'b0; mdu.MDUOp = 4'd0;
    chk("flush_launch_busy", 64'(mdu.Busy), 64'd0);
    chk("flush_move_hi", 64'(mdu.HI), 64'h1);

    // Non-arithmetic ops never launch.
    launch(4'd13, 32'd2, 32'd2);
    chk("op13_busy", 64'(mdu.Busy), 64'd0);
    launch(4'd5, 32'd2, 32'd2);
    chk("op5_busy", 64'(mdu.Busy), 64'd0);

    // Reset mid-divide, with a Start in the reset cycle.
    set_hilo(32'h55, 32'h66);
    launch(4'd3, 32'd100, 32'd7);
    tick(); tick(); tick();
    reset = 1'b1; mdu.Start = 1'b1; mdu.MDUOp = 4'd1; mdu.D1 = 32'd2; mdu.D2 = 32'd2;
    tick();
    reset = 1'b0; mdu.Start = 1'b0; mdu.MDUOp = 4'd0;
    chk("rstmid_busy", 64'(mdu.Busy), 64'd0);
    chk("rstmid_hilo", {mdu.HI, mdu.LO}, 64'd0);
    chk("rstmid_done", 64'(mdu.Done), 64'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); seen_done |= mdu.Done | mdu.Busy; end
    chk("rstmid_quiet", 64'(seen_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e_mdu_param.md
# e_mdu_param

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It holds the architectural HI/LO registers and runs multiply and divide as fixed-latency multi-cycle operations, reporting `Busy` to the stall controller. Unlike the fixed 32-bit MDU, it adds:
- configurable operand width and latencies,
- signed/unsigned multiply-accumulate (madd/msub family),
- an abort input for cancelling an in-flight operation,
- completion and divide-by-zero pulses.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 2.
- `MUL_CYCLES`, 5, Busy duration for multiply and accumulate ops; must be ≥ 1.
- `DIV_CYCLES`, 10, Busy duration for divide ops; must be ≥ 1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `MDUOp` in 4: operation code.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu.
  - 13–15 are treated as none.
- `D1` in WIDTH: forwarded rs.
- `D2` in WIDTH: forwarded rt.
- `Start` in 1: launch request, qualified by `MDUOp`.
- `Flush` in 1: abort the in-flight op and suppress a same-cycle launch or move.
- `Busy` out 1: an operation is in flight.
- `HI` out WIDTH: current HI register.
- `LO` out WIDTH: current LO register.
- `Done` out 1: one-cycle pulse on the cycle a result becomes visible.
- `DivZero` out 1: one-cycle pulse, coincident with `Done`, for a div/divu whose divisor was 0.

## Operation
- **Registers:** HI, LO, a down-counter `cnt` of width clog2(max(MUL_CYCLES, DIV_CYCLES)+1), latched operands, latched op, a Done register and a DivZero register.
- **Launch condition:** `Start` && !`Busy` && !`Flush` && op ∈ {1–4, 9–12}.
  - On launch: latch D1, D2 and op; load `cnt` with MUL_CYCLES (ops 1, 2, 9–12) or DIV_CYCLES (ops 3, 4).
  - `Start` while `Busy`, or with any other op, is ignored.
- **Busy:** `Busy` = (`cnt` != 0).
- **Counting:** each edge with `cnt` > 1 decrements `cnt`.
- **Commit:** the edge with `cnt` == 1 sets `cnt` to 0, writes the result and sets `Done` = 1 for the next cycle.
- **mthi/mtlo (ops 7/8):** write D1 to HI/LO at the edge, only when !`Busy` && !`Flush`; no `Start` needed. When `Busy`, the write is dropped.
- **mfhi/mflo:** not handled internally. HI/LO are continuous outputs and the selection is done outside the block.
- **Arithmetic**, with P = 2·WIDTH-bit product:
  - mult/multu: {HI,LO} = P, signed or unsigned respectively.
  - madd/maddu: {HI,LO} = {HI,LO} + P, mod 2^(2·WIDTH). The HI/LO value used is the one current at launch; it is guaranteed frozen while `Busy`.
  - msub/msubu: {HI,LO} = {HI,LO} − P, mod 2^(2·WIDTH).
  - div/divu: LO = quotient, HI = remainder.
    - Signed division truncates toward zero; the remainder takes the dividend's sign.
    - Signed MIN / −1: LO = MIN, HI = 0.
  - Divisor 0: HI/LO unchanged; the operation still runs DIV_CYCLES; `DivZero` pulses with `Done`.
- **Flush:** sets `cnt` to 0 and clears any pending commit, so HI/LO keep their pre-launch values. `Done` does not pulse.
- **Reset:** HI = 0, LO = 0, `cnt` = 0, `Busy` = 0, `Done` = 0, `DivZero` = 0. Reset during an operation aborts it with no commit.
  - Priority: reset > Flush > commit > launch/move.

## Timing
- **Launch latency:** launch at edge t gives `Busy` = 1 for exactly N cycles after t, with N = MUL_CYCLES or DIV_CYCLES.
- **Commit:** edge t+N. `Busy` falls, the new HI/LO are visible and `Done` = 1, all in the same cycle.
- **Back-to-back:** a new launch is accepted in the first cycle that `Busy` = 0, i.e. the cycle `Done` = 1. That gives a minimum of N+1 cycles between launches.
- **mthi/mtlo:** one-edge latency.
- **Outputs:** all outputs are registered or derived only from registers; there is no combinational path from inputs to outputs.
- **Flush with an active commit:** when `Flush` and the commit edge (`cnt` == 1) coincide, the flush wins and there is no write.

## Test plan
Run all scenarios with WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10.
- **mult:** D1 = −3, D2 = 5, Start → `Busy` high 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1, `Done` pulses once.
- **div:** D1 = 7, D2 = −2 → after 10 Busy cycles, LO = 0xFFFFFFFD (−3), HI = 1.
- **divu by 0:** HI = 0x11 and LO = 0x22 set beforehand; divu 9/0 → after 10 cycles HI/LO unchanged, `DivZero` and `Done` both pulse.
- **madd:** HI = 0, LO = 0xFFFFFFFF; madd 1×1 → HI = 1, LO = 0.
- **maddu then msubu:** msubu 2×3 from {0,4} → HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- **Flush / blocked move:** Flush on cycle 3 of a mult → `Busy` drops the next cycle, HI/LO unchanged, no `Done`. Separately, mtlo 0xAB issued while `Busy` → LO unaffected.
- **Reset mid-divide:** reset asserted mid-divide → next cycle `Busy` = 0 and HI = LO = 0. A Start in the same cycle as reset is ignored.
